// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and widths for the step sequencer
package stepper_pkg;

    localparam int STEP_W   = 16;
    localparam int PERIOD_W = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_DONE
    } state_t;

    function automatic logic [PERIOD_W-1:0] clamp_period(
        input logic [PERIOD_W-1:0] period,
        input logic [PERIOD_W-1:0] min_period
    );
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter; expired_o is high while the count sits at zero
module step_timer
    import stepper_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] value_i,
    output logic                expired_o
);

    logic [PERIOD_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - stepper motor move sequencer: dir setup, fixed-width step pulses, abort
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int PULSE_W    = 1000,
    parameter int DIR_SETUP  = 200,
    parameter int MIN_PERIOD = 2000
) (
    input  logic                clock_in,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STEP_W-1:0]   steps_done
);

    // Timer load values are duration-1 because the timer expires on its zero count.
    localparam logic [PERIOD_W-1:0] SETUP_LEN = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] HI_LEN    = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] HI_P1     = PERIOD_W'(PULSE_W + 1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

    state_t              state_q;
    logic [STEP_W-1:0]   steps_q;
    logic [STEP_W-1:0]   steps_done_q;
    logic [PERIOD_W-1:0] period_q;
    logic                step_q, dir_q, busy_q, done_q, aborted_q, ready_q, zero_q;
    logic                accept, tmr_load, tmr_exp;
    logic [PERIOD_W-1:0] tmr_val;

    assign accept = cmd_valid && ready_q && !abort;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && cmd_steps != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LEN;
                end
            end
            ST_SETUP, ST_PULSE_LO: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = HI_LEN;
                end
            end
            ST_PULSE_HI: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = period_q - HI_P1;
                end
            end
            default: ;
        endcase
    end

    step_timer u_timer (
        .clk_i     (clock_in),
        .rst_ni    (resetn),
        .load_i    (tmr_load),
        .value_i   (tmr_val),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            steps_q      <= '0;
            steps_done_q <= '0;
            period_q     <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            ready_q      <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A zero-step move spends one busy cycle in IDLE before DONE.
                    if (zero_q) begin
                        state_q <= ST_DONE;
                        zero_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (accept) begin
                        steps_q      <= cmd_steps;
                        period_q     <= clamp_period(cmd_period, MIN_P);
                        dir_q        <= cmd_dir;
                        steps_done_q <= '0;
                        aborted_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        ready_q      <= 1'b0;
                        if (cmd_steps == '0) begin
                            zero_q <= 1'b1;
                        end else begin
                            state_q <= ST_SETUP;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP, ST_PULSE_HI, ST_PULSE_LO: begin
                    if (abort) begin
                        state_q   <= ST_DONE;
                        step_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (tmr_exp) begin
                        if (state_q == ST_PULSE_HI) begin
                            state_q <= ST_PULSE_LO;
                            step_q  <= 1'b0;
                        end else if (state_q == ST_PULSE_LO &&
                                     steps_done_q + 1'b1 == steps_q) begin
                            steps_done_q <= steps_done_q + 1'b1;
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            if (state_q == ST_PULSE_LO) begin
                                steps_done_q <= steps_done_q + 1'b1;
                            end
                            state_q <= ST_PULSE_HI;
                            step_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign step       = step_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_done = steps_done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - directed self-checking bench for step_sequencer
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [27:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        step, dir, busy, done, aborted;
    logic [15:0] steps_done;

    int total = 0;
    int bad = 0;

    logic [63:0] step_v, done_v, busy_v, ready_v, dir_v, ab_v;
    int          sd [64];
    logic        saw_done;

    step_sequencer #(.PULSE_W(4), .DIR_SETUP(2), .MIN_PERIOD(6)) dut (
        .clock_in   (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    // Offer a command at a negedge; accept happens on the following posedge (cycle T).
    task automatic issue(input logic [15:0] s, input logic d, input logic [27:0] p, input logic hold);
        wait_ready();
        cmd_steps  = s;
        cmd_dir    = d;
        cmd_period = p;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Sample k = 1..n corresponds to cycle T+k.
    task automatic capture(input int n, input int abort_at);
        step_v = '0; done_v = '0; busy_v = '0; ready_v = '0; dir_v = '0; ab_v = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            step_v[k]  = step;
            done_v[k]  = done;
            busy_v[k]  = busy;
            ready_v[k] = cmd_ready;
            dir_v[k]   = dir;
            ab_v[k]    = aborted;
            sd[k]      = int'(steps_done);
            abort      = (k == abort_at);
        end
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_outs", {58'd0, step, dir, busy, done, aborted}, 64'd0);
        chk("rst_steps_done", 64'(steps_done), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Three steps, period 10
        issue(16'd3, 1'b1, 28'd10, 1'b0);
        capture(36, 0);
        chk("t1_step", step_v, 64'h0000_0000_0781_E078);
        chk("t1_done", done_v, 64'h0000_0002_0000_0000);
        chk("t1_busy", busy_v, 64'h0000_0001_FFFF_FFFE);
        chk("t1_dir", dir_v, 64'h0000_001F_FFFF_FFFE);
        chk("t1_sd12", 64'(sd[12]), 64'd0);
        chk("t1_sd13", 64'(sd[13]), 64'd1);
        chk("t1_sd33", 64'(sd[33]), 64'd3);
        chk("t1_ready34", 64'(ready_v[34]), 64'd1);
        chk("t1_aborted", ab_v, 64'd0);

        // Zero steps
        issue(16'd0, 1'b0, 28'd10, 1'b0);
        capture(4, 0);
        chk("t2_step", step_v, 64'd0);
        chk("t2_done", done_v, 64'h4);
        chk("t2_busy", busy_v, 64'h2);
        chk("t2_dir", dir_v, 64'd0);
        chk("t2_aborted", ab_v, 64'd0);

        // Period below minimum is clamped to 6
        issue(16'd2, 1'b1, 28'd3, 1'b0);
        capture(16, 0);
        chk("t3_step", step_v, 64'h1E78);
        chk("t3_done", done_v, 64'h8000);
        chk("t3_sd15", 64'(sd[15]), 64'd2);

        // Abort during the second cycle of the second pulse
        issue(16'd5, 1'b0, 28'd10, 1'b0);
        capture(18, 14);
        chk("t4_step", step_v, 64'h6078);
        chk("t4_done", done_v, 64'h8000);
        chk("t4_busy", busy_v, 64'h7FFE);
        chk("t4_aborted", ab_v, 64'h78000);
        chk("t4_sd15", 64'(sd[15]), 64'd1);

        // Abort in IDLE only blocks acceptance
        wait_ready();
        cmd_steps = 16'd1; cmd_period = 28'd6; cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_ready", 64'(cmd_ready), 64'd1);
        chk("idle_abort_aborted", 64'(aborted), 64'd1);

        // Reset during PULSE_HI
        issue(16'd3, 1'b1, 28'd10, 1'b0);
        capture(4, 0);
        chk("t5_step_hi", step_v, 64'h18);
        chk("t5_aborted_cleared", ab_v, 64'd0);
        resetn = 1'b0;
        #1;
        chk("t5_rst_outs", {57'd0, cmd_ready, step, dir, busy, done, aborted}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_ready", 64'(cmd_ready), 64'd1);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t5_no_done", 64'(saw_done), 64'd0);

        // cmd_valid held: second command accepted the cycle after done
        issue(16'd1, 1'b1, 28'd6, 1'b1);
        capture(12, 0);
        cmd_valid = 1'b0;
        chk("t6_ready", ready_v, 64'h400);
        chk("t6_busy", busy_v, 64'h19FE);
        chk("t6_done", done_v, 64'h200);
        saw_done = 1'b0;
        for (int k = 0; k < 30 && !saw_done; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t6_second_done", 64'(saw_done), 64'd1);
        chk("t6_second_sd", 64'(steps_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
